fpu_issue_ctrl: RTL and testbench

- Multi-cycle issue/writeback controller wrapped around the combinational floating-point ALU (F_alu).
- Accepts one FP operation at a time from decode over a valid/ready handshake and latches the opcode and operands.
- Holds the ALU inputs stable for LATENCY cycles, captures the result, and presents one writeback pulse to the FP register file.
- Also provides single-entry scoreboard info (pending destination) for decode hazard stalls, an unimplemented-op flag, and flush.

---
 rtl/fp_pkg.sv | 14 +
 rtl/fpu_op_decode.sv | 15 +
 rtl/fpu_issue_ctrl.sv | 123 ++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared encodings for the FP issue controller: supported opcode fields and FSM states.
package fp_pkg;

    localparam logic [4:0] COP_FMT_S = 5'b10000;
    localparam logic [4:0] COP_FMT_D = 5'b10001;
    localparam logic [5:0] FUNC_ADD  = 6'b000000;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WB
    } fpu_state_e;

endpackage

// File: rtl/fpu_op_decode.sv
// Combinational check of whether a cop/func pair is implemented by the wrapped F_alu.
module fpu_op_decode
    import fp_pkg::*;
(
    input  logic [4:0] i_cop,
    input  logic [5:0] i_func,
    output logic       o_supported
);

    logic w_fmt_ok;

    assign w_fmt_ok    = (i_cop == COP_FMT_S) || (i_cop == COP_FMT_D);
    assign o_supported = w_fmt_ok && (i_func == FUNC_ADD);

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue/writeback controller: latches one FP op, holds the ALU inputs for LATENCY cycles,
// then emits a single writeback strobe. Exposes the in-flight destination for hazard stalls.
module fpu_issue_ctrl
    import fp_pkg::*;
#(
    parameter int unsigned LATENCY = 3,
    parameter int unsigned CNT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_cop,
    input  logic [5:0]  req_func,
    input  logic [4:0]  req_fd,
    input  logic [63:0] req_data1,
    input  logic [63:0] req_data2,
    output logic [4:0]  alu_cop,
    output logic [5:0]  alu_func,
    output logic [63:0] alu_data1,
    output logic [63:0] alu_data2,
    input  logic [63:0] alu_result,
    output logic        wb_valid,
    output logic [4:0]  wb_fd,
    output logic [63:0] wb_data,
    output logic        pend_valid,
    output logic [4:0]  pend_fd,
    output logic        unimpl
);

    fpu_state_e  r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]  r_cop;
    logic [5:0]  r_func;
    logic [4:0]  r_fd;
    logic [63:0] r_data1;
    logic [63:0] r_data2;
    logic        r_wb_valid;
    logic [4:0]  r_wb_fd;
    logic [63:0] r_wb_data;
    logic        r_unimpl;

    logic w_supported;
    logic w_accept;

    fpu_op_decode u_decode (
        .i_cop       (req_cop),
        .i_func      (req_func),
        .o_supported (w_supported)
    );

    assign req_ready = (r_state == IDLE) && !flush;
    assign w_accept  = req_valid && req_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_cop      <= '0;
            r_func     <= '0;
            r_fd       <= '0;
            r_data1    <= '0;
            r_data2    <= '0;
            r_wb_valid <= 1'b0;
            r_wb_fd    <= '0;
            r_wb_data  <= '0;
            r_unimpl   <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_unimpl   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_supported) begin
                            r_cop   <= req_cop;
                            r_func  <= req_func;
                            r_fd    <= req_fd;
                            r_data1 <= req_data1;
                            r_data2 <= req_data2;
                            r_cnt   <= CNT_W'(LATENCY - 1);
                            r_state <= EXEC;
                        end else begin
                            r_unimpl <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    // A flush during execution drops the op before it can commit.
                    if (flush) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else if (r_cnt == '0) begin
                        r_wb_data  <= alu_result;
                        r_wb_fd    <= r_fd;
                        r_wb_valid <= 1'b1;
                        r_state    <= WB;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                WB: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign alu_cop    = r_cop;
    assign alu_func   = r_func;
    assign alu_data1  = r_data1;
    assign alu_data2  = r_data2;
    assign wb_valid   = r_wb_valid;
    assign wb_fd      = r_wb_fd;
    assign wb_data    = r_wb_data;
    assign unimpl     = r_unimpl;
    assign pend_valid = (r_state != IDLE);
    assign pend_fd    = pend_valid ? r_fd : 5'd0;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-indexed model.
module tb_fpu_issue_ctrl;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_cop;
    logic [5:0]  req_func;
    logic [4:0]  req_fd;
    logic [63:0] req_data1;
    logic [63:0] req_data2;
    logic [4:0]  alu_cop;
    logic [5:0]  alu_func;
    logic [63:0] alu_data1;
    logic [63:0] alu_data2;
    logic [63:0] alu_result;
    logic        wb_valid;
    logic [4:0]  wb_fd;
    logic [63:0] wb_data;
    logic        pend_valid;
    logic [4:0]  pend_fd;
    logic        unimpl;

    fpu_issue_ctrl #(
        .LATENCY (LAT),
        .CNT_W   (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cop    (req_cop),
        .req_func   (req_func),
        .req_fd     (req_fd),
        .req_data1  (req_data1),
        .req_data2  (req_data2),
        .alu_cop    (alu_cop),
        .alu_func   (alu_func),
        .alu_data1  (alu_data1),
        .alu_data2  (alu_data2),
        .alu_result (alu_result),
        .wb_valid   (wb_valid),
        .wb_fd      (wb_fd),
        .wb_data    (wb_data),
        .pend_valid (pend_valid),
        .pend_fd    (pend_fd),
        .unimpl     (unimpl)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: one in-flight op, identified by the cycle it was accepted in.
    int          cyc;
    bit          m_have;
    int          m_acc;
    int          m_unimpl_cyc;
    logic [4:0]  m_cop;
    logic [5:0]  m_func;
    logic [4:0]  m_fd;
    logic [63:0] m_d1;
    logic [63:0] m_d2;
    logic [63:0] m_res;

    int          wb_seen;
    int          last_wb_cyc;
    logic [4:0]  last_wb_fd;
    logic [63:0] last_wb_data;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_have       = 1'b0;
        m_acc        = -100;
        m_unimpl_cyc = -100;
        m_cop        = '0;
        m_func       = '0;
        m_fd         = '0;
        m_d1         = '0;
        m_d2         = '0;
        m_res        = '0;
    endtask

    // Called at posedge+1 with inputs already driven; checks, updates model, advances a cycle.
    task automatic step();
        bit busy;
        bit rdy;
        bit exp_wb;
        bit sup;
        #1;
        busy   = m_have && (cyc >= m_acc + 1) && (cyc <= m_acc + LAT + 1);
        rdy    = !busy && !flush;
        exp_wb = m_have && (cyc == m_acc + LAT + 1);
        check_eq("req_ready", req_ready, rdy);
        check_eq("pend_valid", pend_valid, busy);
        if (busy) check_eq("pend_fd", pend_fd, m_fd);
        check_eq("wb_valid", wb_valid, exp_wb);
        if (exp_wb) begin
            check_eq("wb_fd", wb_fd, m_fd);
            check_eq("wb_data", wb_data, m_res);
        end
        check_eq("unimpl", unimpl, cyc == m_unimpl_cyc);
        check_eq("alu_cop", alu_cop, m_cop);
        check_eq("alu_func", alu_func, m_func);
        check_eq("alu_data1", alu_data1, m_d1);
        check_eq("alu_data2", alu_data2, m_d2);
        if (wb_valid === 1'b1) begin
            wb_seen++;
            last_wb_cyc  = cyc;
            last_wb_fd   = wb_fd;
            last_wb_data = wb_data;
        end
        if (m_have && cyc == m_acc + LAT) m_res = alu_result;
        if (busy && flush && cyc <= m_acc + LAT) m_have = 1'b0;
        else if (exp_wb) m_have = 1'b0;
        if (rdy && req_valid) begin
            sup = (req_cop == 5'b10000 || req_cop == 5'b10001) && req_func == 6'd0;
            if (sup) begin
                m_have = 1'b1;
                m_acc  = cyc;
                m_cop  = req_cop;
                m_func = req_func;
                m_fd   = req_fd;
                m_d1   = req_data1;
                m_d2   = req_data2;
            end else begin
                m_unimpl_cyc = cyc + 1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_op(input logic [4:0] cop, input logic [5:0] func, input logic [4:0] fd,
                          input logic [63:0] d1, input logic [63:0] d2);
        req_cop   = cop;
        req_func  = func;
        req_fd    = fd;
        req_data1 = d1;
        req_data2 = d2;
    endtask

    // Asserts reset between edges; outputs must fall without waiting for a clock.
    task automatic mid_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        check_eq({tag, "_pend_valid"}, pend_valid, 1'b0);
        check_eq({tag, "_wb_valid"}, wb_valid, 1'b0);
        check_eq({tag, "_unimpl"}, unimpl, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        cyc += 2;
        model_reset();
    endtask

    int base;
    int wb0;

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        req_valid = 1'b0;
        alu_result = '0;
        set_op(5'd0, 6'd0, 5'd0, 64'd0, 64'd0);
        cyc = 0;
        wb_seen = 0;
        model_reset();
        #3;
        check_eq("rst_wb_valid", wb_valid, 1'b0);
        check_eq("rst_pend_valid", pend_valid, 1'b0);
        check_eq("rst_alu_data1", alu_data1, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // ADD.S 1.0 + 2.0
        base = cyc;
        wb0  = wb_seen;
        set_op(5'b10000, 6'd0, 5'd5, 64'h3F800000_00000000, 64'h40000000_00000000);
        alu_result = 64'h40400000_00000000;
        req_valid  = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (6) step();
        check_eq("adds_wb_count", wb_seen - wb0, 1);
        check_eq("adds_wb_cycle", last_wb_cyc - base, 4);
        check_eq("adds_wb_fd", last_wb_fd, 5'd5);
        check_eq("adds_wb_data", last_wb_data, 64'h40400000_00000000);

        // Unsupported op is consumed and flagged, latches untouched.
        wb0 = wb_seen;
        set_op(5'b10000, 6'b000010, 5'd9, 64'hDEAD, 64'hBEEF);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (4) step();
        check_eq("unimpl_no_wb", wb_seen - wb0, 0);
        check_eq("unimpl_alu_data1", alu_data1, 64'h3F800000_00000000);

        // Back-to-back with req_valid held.
        base = cyc;
        wb0  = wb_seen;
        set_op(5'b10001, 6'd0, 5'd7, {$urandom, $urandom}, {$urandom, $urandom});
        req_valid = 1'b1;
        alu_result = {$urandom, $urandom};
        step();
        set_op(5'b10000, 6'd0, 5'd8, {$urandom, $urandom}, {$urandom, $urandom});
        for (int i = 1; i < 12; i++) begin
            alu_result = {$urandom, $urandom};
            if (i == 6) req_valid = 1'b0;
            step();
        end
        check_eq("b2b_wb_count", wb_seen - wb0, 2);
        check_eq("b2b_last_wb_cycle", last_wb_cyc - base, 9);
        check_eq("b2b_last_fd", last_wb_fd, 5'd8);

        // Flush during EXEC, then a normal op.
        wb0 = wb_seen;
        set_op(5'b10000, 6'd0, 5'd3, {$urandom, $urandom}, {$urandom, $urandom});
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (4) step();
        check_eq("flush_no_wb", wb_seen - wb0, 0);
        set_op(5'b10001, 6'd0, 5'd4, {$urandom, $urandom}, {$urandom, $urandom});
        req_valid  = 1'b1;
        alu_result = 64'h0123_4567_89AB_CDEF;
        step();
        req_valid = 1'b0;
        repeat (5) step();
        check_eq("after_flush_wb", wb_seen - wb0, 1);
        check_eq("after_flush_data", last_wb_data, 64'h0123_4567_89AB_CDEF);

        // Flush coincident with a request in IDLE.
        base = cyc;
        wb0  = wb_seen;
        set_op(5'b10000, 6'd0, 5'd11, {$urandom, $urandom}, {$urandom, $urandom});
        flush     = 1'b1;
        req_valid = 1'b1;
        step();
        flush = 1'b0;
        step();
        req_valid = 1'b0;
        repeat (5) step();
        check_eq("idle_flush_wb_cycle", last_wb_cyc - base, 5);

        // Async reset mid-EXEC and mid-WB.
        wb0 = wb_seen;
        set_op(5'b10000, 6'd0, 5'd12, {$urandom, $urandom}, {$urandom, $urandom});
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        mid_reset("rst_exec");
        repeat (5) step();
        check_eq("rst_exec_no_wb", wb_seen - wb0, 0);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (LAT) step();
        mid_reset("rst_wb");
        repeat (3) step();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            int sel;
            sel = int'($urandom_range(0, 3));
            req_valid = $urandom_range(0, 1) == 1;
            req_cop   = (sel == 1) ? 5'b10001 : (sel == 2) ? 5'($urandom) : 5'b10000;
            req_func  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            req_fd    = 5'($urandom);
            req_data1 = {$urandom, $urandom};
            req_data2 = {$urandom, $urandom};
            flush     = $urandom_range(0, 9) == 0;
            alu_result = {$urandom, $urandom};
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
